systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Operand feeder for the `array_size` x `array_size` systolic MAC array. It buffers one tile's worth of k-step operand vectors (one data byte per row and one weight byte per column per step) through a valid/ready load port. On `start`, it clears the array and streams the vectors out with diagonal skew: lane i is delayed by i cycles and zero-padded. It then waits for the array to drain and pulses `done`. It sits between the operand buffers and the array's `datain`/`weightin` inputs.

## Interface
- `array_size`, 4: rows/columns of the array; number of byte lanes.
- `max_k`, 16: buffer depth; maximum k-steps per tile.
- `k_width`, `$clog2(max_k+1)`: width of k counters.

- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: load beat valid.
- `in_ready` out 1: feeder accepts a load beat.
- `in_data` in 8*array_size: row operands for one k-step; byte i goes to row i.
- `in_weight` in 8*array_size: column operands for one k-step; byte j goes to column j.
- `in_last` in 1: marks the final beat of the tile.
- `start` in 1: begin streaming the loaded tile.
- `array_clr` out 1: one-cycle clear pulse to the array's reset.
- `datain` out 8*array_size: skewed row stream, registered.
- `weightin` out 8*array_size: skewed column stream, registered.
- `busy` out 1: high from CLEAR through FLUSH.
- `done` out 1: one-cycle pulse when the tile has fully drained.

## Operation
- States: LOAD, LOADED, CLEAR, STREAM, FLUSH, DONE.
- **LOAD**
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready`. It is written to `buf[wr_ptr]`, and `wr_ptr` increments.
  - If the accepted beat has `in_last`=1 or `wr_ptr`==`max_k`-1: `k_len` = `wr_ptr`+1, go to LOADED.
  - `start` is ignored in LOAD.
- **LOADED**
  - `in_ready`=0.
  - On `start`=1, go to CLEAR.
  - `in_valid` is ignored.
- **CLEAR**
  - One cycle.
  - `array_clr`=1 is registered, so it is visible the cycle after CLEAR is entered.
  - Stream counter t=0.
- **STREAM**
  - Lasts `k_len`+`array_size`-1 cycles, t=0..`k_len`+`array_size`-2.
  - Row lane i: `datain` byte i = `buf[t-i].data` byte i if 0<=t-i<`k_len`, else 0.
  - Column lane j: `weightin` byte j = `buf[t-j].weight` byte j under the same rule.
- **FLUSH**
  - Lasts 2*`array_size` cycles.
  - `datain`/`weightin` = 0.
- **DONE**
  - One cycle: `done`=1, `wr_ptr`=0.
  - Go to LOAD.
  - The buffer is not cleared; the next tile overwrites it.
- Outputs outside STREAM are all-zero lanes. Only `in_ready` is combinational from state.
- Data are 8-bit unsigned bytes passed through unchanged. There is no arithmetic on the payload.
- A beat with `in_last`=1 as the first beat gives `k_len`=1. Valid `k_len` range is 1..`max_k`.
- A full buffer (`max_k` beats without `in_last`) forces the LOADED transition. The implicit last beat is treated exactly like `in_last`.

## Timing
- **Reset values:** state=LOAD, `wr_ptr`=0, `k_len`=0, `in_ready`=1 (combinational from LOAD), `array_clr`=0, `datain`=0, `weightin`=0, `busy`=0, `done`=0.
- **Reset mid-operation** (any state): on the next edge, all of the above apply. A partial tile is discarded, and no `done` is issued.
- **Registered outputs:** `datain`, `weightin`, `array_clr`, `busy` and `done` change on the edge after the state or counter that produces them.
- **Latency:**
  - `start` sampled at edge n gives `array_clr` high in cycle n+1.
  - The first nonzero lane-0 output appears in cycle n+2.
  - `done` is high in cycle n+1+1+(`k_len`+`array_size`-1)+2*`array_size`.
  - Example: `array_size`=4, `k_len`=4 gives `done` at n+17.
- **Back-to-back:** `start` held high continuously does not restart streaming. A new tile needs a new load.
- **Simultaneous events:** `in_valid`+`start` in LOAD accepts the beat and ignores `start`. `start` on the same edge that LOADED is entered is ignored. `start` is only sampled in LOADED.
- **Throughput:** one beat per cycle while loading, with no bubbles.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → all outputs 0 and `in_ready`=1. Reassert `reset` during STREAM → next cycle `datain`=0, `busy`=0, `in_ready`=1, no `done`.
- **Basic tile:** `array_size`=4; load 4 beats with `in_data` byte i = 0x10*k+i, `weightin` analog = 0x80+0x10*k+j, `in_last` on beat 3; pulse `start`.
  - `array_clr` one cycle.
  - Lane 2 of `datain` reads 0,0,0x02,0x12,0x22,0x32,0,… over STREAM cycles t=0..6.
  - `done` at start+17.
- **Single-beat tile:** `in_last` on the first beat (`k_len`=1) → each lane i carries its byte only at t=i; STREAM lasts 4 cycles; `done` at start+14.
- **Full buffer:** 16 beats without `in_last` → `in_ready` drops after beat 16; a 17th `in_valid` is not accepted; STREAM lasts 19 cycles.
- **Protocol misuse:**
  - `start` during LOAD → ignored.
  - `in_valid` during LOADED/STREAM → not accepted; buffer contents unchanged.
  - `in_valid` toggling randomly during LOAD → beats stored in order with no gaps.
- **Back-to-back tiles:** after `done`, load a second tile of 2 beats → streams only the new values; stale buffer entries at index ≥2 never appear on outputs.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one tile of k-step operand vectors, then streams
// them diagonally skewed into an array_size x array_size systolic MAC array.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - load handshake; in_data/in_weight/in_last payload
//   start                - begin streaming a loaded tile
//   array_clr            - one-cycle clear pulse to the array
//   datain/weightin      - skewed row/column byte lanes (registered)
//   busy, done           - busy from CLEAR through FLUSH; done pulse at end
module systolic_feeder #(
  parameter int array_size = 4,
  parameter int max_k      = 16,
  parameter int k_width    = $clog2(max_k + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*array_size-1:0] in_data,
  input  logic [8*array_size-1:0] in_weight,
  input  logic                    in_last,
  input  logic                    start,
  output logic                    array_clr,
  output logic [8*array_size-1:0] datain,
  output logic [8*array_size-1:0] weightin,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(max_k);
  localparam int CW = $clog2(max_k + 2*array_size + 1);
  localparam int LW = 8*array_size;

  typedef enum logic [2:0] {
    LOAD, LOADED, CLEAR, STREAM, FLUSH, DONE
  } state_t;

  state_t state;

  logic [LW-1:0]      dbuf [max_k];
  logic [LW-1:0]      wbuf [max_k];
  logic [k_width-1:0] wr_ptr;
  logic [k_width-1:0] k_len;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      stream_last;
  logic [CW-1:0]      off;
  logic [LW-1:0]      d_next;
  logic [LW-1:0]      w_next;
  logic               accept;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;

  // Final t of STREAM: k_len + array_size - 2 (k_len >= 1, no underflow)
  assign stream_last = CW'(k_len) + CW'(array_size - 1) - CW'(1);

  // Operand storage carries no reset; stale entries are never read
  // because lane selection is bounded by k_len.
  always_ff @(posedge clk) begin
    if (accept) begin
      dbuf[wr_ptr[AW-1:0]] <= in_data;
      wbuf[wr_ptr[AW-1:0]] <= in_weight;
    end
  end

  // Lane i shows beat t-i while that index is inside the tile.
  always_comb begin
    d_next = '0;
    w_next = '0;
    off    = '0;
    if (state == STREAM) begin
      for (int i = 0; i < array_size; i++) begin
        off = cnt - CW'(i);
        if (cnt >= CW'(i) && off < CW'(k_len)) begin
          d_next[8*i +: 8] = dbuf[AW'(off)][8*i +: 8];
          w_next[8*i +: 8] = wbuf[AW'(off)][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      k_len     <= '0;
      cnt       <= '0;
      array_clr <= 1'b0;
      datain    <= '0;
      weightin  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      array_clr <= (state == CLEAR);
      busy      <= (state == CLEAR) ||
                   (state == STREAM) ||
                   (state == FLUSH);
      done      <= (state == DONE);
      datain    <= d_next;
      weightin  <= w_next;
      unique case (state)
        LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + k_width'(1);
            if (in_last ||
                wr_ptr == k_width'(max_k - 1)) begin
              k_len <= wr_ptr + k_width'(1);
              state <= LOADED;
            end
          end
        end
        LOADED: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          cnt   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (cnt == stream_last) begin
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FLUSH: begin
          if (cnt == CW'(2*array_size - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          wr_ptr <= '0;
          state  <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: table of tiles streamed against a
// scoreboard of per-cycle expected outputs, plus reset corner sequences.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_weight;
  logic        in_last;
  logic        start;
  logic        array_clr;
  logic [31:0] datain;
  logic [31:0] weightin;
  logic        busy;
  logic        done;

  systolic_feeder #(
    .array_size(4),
    .max_k(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_weight(in_weight),
    .in_last(in_last),
    .start(start),
    .array_clr(array_clr),
    .datain(datain),
    .weightin(weightin),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         nbeats;
    bit         use_last;
    logic [7:0] seed;
    bit         gaps;
    bit         hold;
    bit         noise;
    int         dlat;
  } tile_t;

  typedef struct {
    logic        clr;
    logic        bsy;
    logic        dn;
    logic [31:0] d;
    logic [31:0] w;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdat [16];
  logic [31:0] mwt  [16];
  exp_t        sb [$];
  tile_t       tiles [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] base,
                                      input int b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = base + 8'(16*b) + 8'(i);
    return r;
  endfunction

  function automatic logic [31:0] lane(input bit wt,
                                       input int t,
                                       input int k);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < k)
        r[8*i +: 8] = wt ? mwt[t-i][8*i +: 8]
                         : mdat[t-i][8*i +: 8];
    return r;
  endfunction

  task automatic load_tile(input int n, input bit use_last,
                           input logic [7:0] seed, input bit gaps);
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid  = 1'b0;
          in_data   = $urandom;
          in_weight = $urandom;
          start     = 1'b1;
          tick();
        end
      end
      in_valid  = 1'b1;
      start     = 1'b1;
      in_data   = pat(seed, b);
      in_weight = pat(8'h80 + seed, b);
      in_last   = use_last && (b == n - 1);
      mdat[b]   = in_data;
      mwt[b]    = in_weight;
      chk("in_ready_load", 32'(in_ready), 32'd1);
      tick();
    end
    in_last   = 1'b0;
    start     = 1'b0;
    in_data   = 32'hEEEE_EEEE;
    in_weight = 32'hDDDD_DDDD;
    chk("in_ready_loaded", 32'(in_ready), 32'd0);
    tick();
    tick();
    in_valid = 1'b0;
    chk("loaded_no_clr", 32'(array_clr), 32'd0);
    chk("loaded_no_busy", 32'(busy), 32'd0);
    chk("loaded_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic run_tile(input int k, input int dlat,
                          input bit hold, input bit noise);
    exp_t e;
    start = 1'b1;
    for (int c = 1; c <= dlat; c++) begin
      e.clr = (c == 1);
      e.bsy = (c < dlat);
      e.dn  = (c == dlat);
      e.d   = lane(1'b0, c - 2, k);
      e.w   = lane(1'b1, c - 2, k);
      sb.push_back(e);
    end
    tick();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= dlat; c++) begin
      in_valid  = noise && (c <= dlat - 2);
      in_data   = $urandom;
      in_weight = $urandom;
      tick();
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("array_clr", 32'(array_clr), 32'(e.clr));
        chk("busy", 32'(busy), 32'(e.bsy));
        chk("done", 32'(done), 32'(e.dn));
        chk("datain", datain, e.d);
        chk("weightin", weightin, e.w);
      end
    end
    in_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_clr", 32'(array_clr), 32'd0);
      chk("post_done", 32'(done), 32'd0);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    tiles[0] = '{4,  1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 17};
    tiles[1] = '{1,  1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 14};
    tiles[2] = '{16, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 29};
    tiles[3] = '{2,  1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 15};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    in_last   = 1'b0;
    start     = 1'b0;
    tick();
    tick();
    chk("rst_clr", 32'(array_clr), 32'd0);
    chk("rst_datain", datain, 32'd0);
    chk("rst_weightin", weightin, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    tick();

    load_tile(4, 1'b1, 8'h33, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_datain", datain, 32'd0);
    chk("mid_rst_weightin", weightin, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (30) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    for (int n = 0; n < 4; n++) begin
      load_tile(tiles[n].nbeats, tiles[n].use_last,
                tiles[n].seed, tiles[n].gaps);
      run_tile(tiles[n].nbeats, tiles[n].dlat,
               tiles[n].hold, tiles[n].noise);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
